// File: rtl/spi_rx_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI receive deserializer slice.
//   DEFAULT_DATA_W : default number of bits per received word
//   state_t        : receiver FSM states (IDLE, SHIFT)
// ---------------------------------------------------------------------------
package spi_pkg;

   localparam int DEFAULT_DATA_W = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage : spi_pkg

// File: rtl/spi_rx_deserializer_if.sv
// ---------------------------------------------------------------------------
// spi_rx_deserializer_if
// Word-level output channel of the SPI receive deserializer.
//   rx_data     : last completed word
//   rx_valid    : rx_data holds a word the consumer has not taken yet
//   rx_ready    : consumer takes rx_data when rx_valid and rx_ready are high
//   overrun     : sticky flag, a completed word was dropped
//   overrun_clr : synchronous clear request for overrun
// Modports:
//   master : the deserializer (drives data/valid/overrun)
//   slave  : the consumer (drives ready/overrun_clr)
// ---------------------------------------------------------------------------
interface spi_rx_deserializer_if
   import spi_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
);

   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              overrun;
   logic              overrun_clr;

   modport master (
      output rx_data,
      output rx_valid,
      output overrun,
      input  rx_ready,
      input  overrun_clr
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  overrun,
      output rx_ready,
      output overrun_clr
   );

endinterface : spi_rx_deserializer_if

// File: rtl/spi_rx_deserializer_sclk_edge_det.sv
// ---------------------------------------------------------------------------
// sclk_edge_det
// Rising-edge detector for the divided serial clock. sclk is already
// registered in the clk_in domain, so a single history flop is enough.
// The history flop tracks sclk at all times, independent of whether a
// transaction is active, so a clock that is already high when a
// transaction starts does not look like a fresh edge.
// Ports:
//   clk_in : system clock (rising edge)
//   rst    : asynchronous active-high reset
//   sclk   : divided serial clock, synchronous to clk_in
//   rise   : one-cycle pulse, sclk high now and low in the previous cycle
// ---------------------------------------------------------------------------
module sclk_edge_det (
   input  logic clk_in,
   input  logic rst,
   input  logic sclk,
   output logic rise
);

   logic sclk_q;

   // History of sclk, one clk_in cycle old.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         sclk_q <= 1'b0;
      end else begin
         sclk_q <= sclk;
      end
   end

   assign rise = sclk & ~sclk_q;

endmodule : sclk_edge_det

// File: rtl/spi_rx_deserializer.sv
// ---------------------------------------------------------------------------
// spi_rx_deserializer
// Collects DATA_W bits of serial data sampled on sclk rising edges while
// en (chip select) is asserted and presents each completed word on a
// valid/ready channel. A word completed while the previous one is still
// unconsumed is dropped and flagged through the sticky overrun bit.
// Parameters:
//   DATA_W    : bits per word (2..16)
//   MSB_FIRST : 1 = first sampled bit ends up in rx_data[DATA_W-1],
//               0 = first sampled bit ends up in rx_data[0]
// Ports:
//   clk_in : system clock (rising edge)
//   rst    : asynchronous active-high reset
//   en     : transaction active, synchronous to clk_in
//   sclk   : divided serial clock, registered in the clk_in domain
//   miso   : serial data, valid around each sclk rising edge
//   busy   : high while the FSM is in SHIFT
//   rx     : word output channel (master side of spi_rx_deserializer_if)
// ---------------------------------------------------------------------------
module spi_rx_deserializer
   import spi_pkg::*;
#(
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                   clk_in,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   sclk,
   input  logic                   miso,
   output logic                   busy,
   spi_rx_deserializer_if.master  rx
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   state_t            state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_nxt;
   logic              rise;
   logic              sample;
   logic              last_bit;
   logic              complete;
   logic              accept;
   logic              handshake;

   sclk_edge_det u_edge (
      .clk_in (clk_in),
      .rst    (rst),
      .sclk   (sclk),
      .rise   (rise)
   );

   // An edge only counts while already in SHIFT and en is still high; the
   // cycle where en rises (still IDLE) and the cycle where en falls both
   // ignore edges.
   assign sample    = (state == SHIFT) && en && rise;
   assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
   assign complete  = sample && last_bit;
   assign handshake = rx.rx_valid && rx.rx_ready;

   // A completed word is taken when the output slot is empty or is being
   // emptied in this very cycle; otherwise it is dropped as an overrun.
   assign accept    = complete && (!rx.rx_valid || rx.rx_ready);

   assign busy      = (state == SHIFT);

   // Next shift register value including the bit sampled on this edge.
   // This is also the value loaded into rx_data on completion, so the word
   // appears one clk_in cycle after the final sampling edge.
   always_comb begin
      shreg_nxt = shreg;
      if (MSB_FIRST) begin
         shreg_nxt = {shreg[DATA_W-2:0], miso};
      end else begin
         shreg_nxt = {miso, shreg[DATA_W-1:1]};
      end
   end

   // Two-state FSM: SHIFT for as long as chip select is asserted.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (!en) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Bit counter and shift register. Outside an active transaction both
   // are held cleared, so a word aborted by en falling leaves nothing
   // behind for the next transaction.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         bit_cnt <= '0;
         shreg   <= '0;
      end else if ((state != SHIFT) || !en) begin
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (rise) begin
         shreg <= shreg_nxt;
         if (last_bit) begin
            bit_cnt <= '0;
         end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
      end
   end

   // Output slot. A completion that is accepted refills the slot even when
   // the consumer takes the old word in the same cycle, so rx_valid stays
   // high in that case.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         rx.rx_data  <= '0;
         rx.rx_valid <= 1'b0;
      end else if (accept) begin
         rx.rx_data  <= shreg_nxt;
         rx.rx_valid <= 1'b1;
      end else if (handshake) begin
         rx.rx_valid <= 1'b0;
      end
   end

   // Sticky overrun flag; a new drop in the same cycle as a clear request
   // keeps the flag set.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         rx.overrun <= 1'b0;
      end else if (complete && !accept) begin
         rx.overrun <= 1'b1;
      end else if (rx.overrun_clr) begin
         rx.overrun <= 1'b0;
      end
   end

endmodule : spi_rx_deserializer

// File: tb/tb_spi_rx_deserializer.sv
// ---------------------------------------------------------------------------
// tb_spi_rx_deserializer
// Bench for spi_rx_deserializer. Two instances share one stimulus stream:
// inst 0 with MSB_FIRST=1, inst 1 with MSB_FIRST=0. A queue-based model
// collects sampled bits and builds both word orders; a negedge process
// compares every output of both instances against it each cycle, and the
// directed sequence adds literal expectations for each scenario.
// ---------------------------------------------------------------------------
module tb_spi_rx_deserializer;
   import spi_pkg::*;

   logic clk_in = 1'b0;
   logic rst    = 1'b1;
   logic en     = 1'b0;
   logic sclk   = 1'b0;
   logic miso   = 1'b0;
   logic rx_ready    = 1'b0;
   logic overrun_clr = 1'b0;
   logic busy0, busy1;

   int n_cmp  = 0;
   int n_fail = 0;
   int vc0    = 0;

   spi_rx_deserializer_if #(.DATA_W(8)) rx0 ();
   spi_rx_deserializer_if #(.DATA_W(8)) rx1 ();

   assign rx0.rx_ready    = rx_ready;
   assign rx0.overrun_clr = overrun_clr;
   assign rx1.rx_ready    = rx_ready;
   assign rx1.overrun_clr = overrun_clr;

   spi_rx_deserializer #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_msb (
      .clk_in (clk_in),
      .rst    (rst),
      .en     (en),
      .sclk   (sclk),
      .miso   (miso),
      .busy   (busy0),
      .rx     (rx0)
   );

   spi_rx_deserializer #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk_in (clk_in),
      .rst    (rst),
      .en     (en),
      .sclk   (sclk),
      .miso   (miso),
      .busy   (busy1),
      .rx     (rx1)
   );

   always #5 clk_in = ~clk_in;

   // Single comparison point for model checks and literal checks.
   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic       m_prev_sclk = 1'b0;
   logic       m_active    = 1'b0;
   logic       m_q[$];
   logic [7:0] m_data[2]   = '{8'h00, 8'h00};
   logic       m_valid[2]  = '{1'b0, 1'b0};
   logic       m_ovr[2]    = '{1'b0, 1'b0};
   logic       m_rise;
   logic       m_done;
   logic       m_reject;
   logic [7:0] m_word[2];

   // Model: remember sampled bits in arrival order; after eight of them,
   // arrival index i becomes bit 7-i (MSB first) or bit i (LSB first).
   always @(posedge clk_in) begin
      if (rst) begin
         m_prev_sclk = 1'b0;
         m_active    = 1'b0;
         m_q.delete();
         for (int d = 0; d < 2; d++) begin
            m_data[d]  = 8'h00;
            m_valid[d] = 1'b0;
            m_ovr[d]   = 1'b0;
         end
      end else begin
         m_rise      = sclk && !m_prev_sclk;
         m_prev_sclk = sclk;
         m_done      = 1'b0;
         if (m_active && !en) begin
            m_q.delete();
         end else if (m_active && en && m_rise) begin
            m_q.push_back(miso);
            if (m_q.size() == 8) begin
               for (int i = 0; i < 8; i++) begin
                  m_word[0][7-i] = m_q[i];
                  m_word[1][i]   = m_q[i];
               end
               m_done = 1'b1;
               m_q.delete();
            end
         end
         for (int d = 0; d < 2; d++) begin
            m_reject = m_done && m_valid[d] && !rx_ready;
            if (m_done && !m_reject) begin
               m_data[d]  = m_word[d];
               m_valid[d] = 1'b1;
            end else if (!m_done && m_valid[d] && rx_ready) begin
               m_valid[d] = 1'b0;
            end
            if (m_reject) begin
               m_ovr[d] = 1'b1;
            end else if (overrun_clr) begin
               m_ovr[d] = 1'b0;
            end
         end
         m_active = en;
      end
   end

   // Every-cycle comparison against the model; while rst is high every
   // output must already read zero.
   always @(negedge clk_in) begin
      checkOutput("msb.rx_data",  {8'h00, rx0.rx_data}, rst ? 16'h0 : {8'h00, m_data[0]});
      checkOutput("msb.rx_valid", {15'h0, rx0.rx_valid}, rst ? 16'h0 : {15'h0, m_valid[0]});
      checkOutput("msb.overrun",  {15'h0, rx0.overrun},  rst ? 16'h0 : {15'h0, m_ovr[0]});
      checkOutput("msb.busy",     {15'h0, busy0},        rst ? 16'h0 : {15'h0, m_active});
      checkOutput("lsb.rx_data",  {8'h00, rx1.rx_data}, rst ? 16'h0 : {8'h00, m_data[1]});
      checkOutput("lsb.rx_valid", {15'h0, rx1.rx_valid}, rst ? 16'h0 : {15'h0, m_valid[1]});
      checkOutput("lsb.overrun",  {15'h0, rx1.overrun},  rst ? 16'h0 : {15'h0, m_ovr[1]});
      checkOutput("lsb.busy",     {15'h0, busy1},        rst ? 16'h0 : {15'h0, m_active});
      if (rx0.rx_valid) begin
         vc0++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // One divide-by-4 sclk period: two cycles low with data set up, two
   // cycles high. Optional ready/clear pulses line up with the cycle in
   // which the rising edge is detected.
   task automatic applyStimulus(input logic b, input logic rdy, input logic clr);
      sclk = 1'b0;
      miso = b;
      step();
      step();
      sclk = 1'b1;
      if (rdy) rx_ready = 1'b1;
      if (clr) overrun_clr = 1'b1;
      step();
      if (rdy) rx_ready = 1'b0;
      if (clr) overrun_clr = 1'b0;
      step();
   endtask

   // Sends w[7] first, so the MSB-first instance should reproduce w.
   task automatic sendWord(input logic [7:0] w, input logic rdy_last, input logic clr_last);
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(w[i], rdy_last && (i == 0), clr_last && (i == 0));
      end
   endtask

   initial begin
      // Reset state
      repeat (3) step();
      checkOutput("rst.rx_data",  {8'h00, rx0.rx_data}, 16'h0000);
      checkOutput("rst.rx_valid", {15'h0, rx0.rx_valid}, 16'h0000);
      checkOutput("rst.busy",     {15'h0, busy0},        16'h0000);
      rst = 1'b0;
      step();

      // 1,0,1,0,0,1,0,1 with consumer always ready
      en = 1'b1;
      rx_ready = 1'b1;
      step();
      vc0 = 0;
      sendWord(8'hA5, 1'b0, 1'b0);
      step();
      checkOutput("a5.msb_data",   {8'h00, rx0.rx_data}, 16'h00A5);
      checkOutput("a5.lsb_data",   {8'h00, rx1.rx_data}, 16'h00A5);
      checkOutput("a5.valid_cyc",  16'(vc0), 16'd1);
      checkOutput("a5.valid_low",  {15'h0, rx0.rx_valid}, 16'h0000);

      // 1,0,0,0,0,0,0,0: opposite orders give 80 and 01
      sendWord(8'h80, 1'b0, 1'b0);
      step();
      checkOutput("01.msb_data", {8'h00, rx0.rx_data}, 16'h0080);
      checkOutput("01.lsb_data", {8'h00, rx1.rx_data}, 16'h0001);

      // Overrun: 3C pending, C3 dropped, then cleared and consumed
      rx_ready = 1'b0;
      sendWord(8'h3C, 1'b0, 1'b0);
      sendWord(8'hC3, 1'b0, 1'b0);
      checkOutput("ovr.msb_data",  {8'h00, rx0.rx_data}, 16'h003C);
      checkOutput("ovr.msb_valid", {15'h0, rx0.rx_valid}, 16'h0001);
      checkOutput("ovr.msb_flag",  {15'h0, rx0.overrun},  16'h0001);
      checkOutput("ovr.lsb_flag",  {15'h0, rx1.overrun},  16'h0001);
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      checkOutput("ovr.cleared", {15'h0, rx0.overrun}, 16'h0000);
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      checkOutput("ovr.consumed", {15'h0, rx0.rx_valid}, 16'h0000);

      // en dropped after 5 edges, idle sclk activity, then a clean 96
      rx_ready = 1'b1;
      vc0 = 0;
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sclk = 1'b0; step(); step();
         sclk = 1'b1; step(); step();
      end
      en = 1'b1;
      step();
      step();
      sendWord(8'h96, 1'b0, 1'b0);
      step();
      checkOutput("abort.msb_data", {8'h00, rx0.rx_data}, 16'h0096);
      checkOutput("abort.lsb_data", {8'h00, rx1.rx_data}, 16'h0069);
      checkOutput("abort.valid_cyc", 16'(vc0), 16'd1);

      // Reset mid-word with a pending word, then 8 fresh edges
      rx_ready = 1'b0;
      sendWord(8'hAB, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      checkOutput("mrst.rx_data",  {8'h00, rx0.rx_data}, 16'h0000);
      checkOutput("mrst.rx_valid", {15'h0, rx0.rx_valid}, 16'h0000);
      checkOutput("mrst.busy",     {15'h0, busy0},        16'h0000);
      step();
      rst = 1'b0;
      for (int i = 7; i >= 1; i--) applyStimulus(8'hE7 >> i, 1'b0, 1'b0);
      checkOutput("mrst.no_early", {15'h0, rx0.rx_valid}, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("mrst.word",  {8'h00, rx0.rx_data}, 16'h00E7);
      checkOutput("mrst.valid", {15'h0, rx0.rx_valid}, 16'h0001);
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;

      // 11 pending, 5A completes exactly as the consumer takes 11
      sendWord(8'h11, 1'b0, 1'b0);
      sendWord(8'h5A, 1'b1, 1'b0);
      checkOutput("swap.data",  {8'h00, rx0.rx_data}, 16'h005A);
      checkOutput("swap.valid", {15'h0, rx0.rx_valid}, 16'h0001);
      checkOutput("swap.ovr",   {15'h0, rx0.overrun},  16'h0000);

      // Drop coincides with a clear request: the flag stays set
      sendWord(8'h77, 1'b0, 1'b1);
      checkOutput("setwins.ovr",  {15'h0, rx0.overrun}, 16'h0001);
      checkOutput("setwins.data", {8'h00, rx0.rx_data}, 16'h005A);

      en = 1'b0;
      repeat (4) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_spi_rx_deserializer

// File: doc/spi_rx_deserializer.md
SPI_RX_DESERIALIZER -- requirements
Module: spi_rx_deserializer

Interface
REQ-001 Parameter: DATA_W, default 8, bits per received word (allowed range 2..16).
REQ-002 Parameter: MSB_FIRST, default 1; 1 = first sampled bit lands in rx_data[DATA_W-1], 0 = lands in rx_data[0].
REQ-003 clk_in  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  transaction active (chip-select asserted); synchronous to clk_in.
REQ-006 sclk  input  1  divided serial clock from the clock divider, registered in the clk_in domain.
REQ-007 miso  input  1  serial data from the flash, valid around each sclk rising edge.
REQ-008 rx_data  output  DATA_W  last completed word.
REQ-009 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-010 rx_ready  input  1  consumer accepts rx_data when rx_valid=1 and rx_ready=1.
REQ-011 overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 overrun_clr  input  1  synchronous clear of overrun.
REQ-013 busy  output  1  high while in SHIFT state.

Function
REQ-014 The block SHALL detect an sclk rising edge as sclk=1 in the current cycle and sclk=0 in the previous clk_in cycle (one-cycle edge pulse).
REQ-015 The FSM SHALL have two states: IDLE and SHIFT; IDLE->SHIFT when en=1, SHIFT->IDLE when en=0.
REQ-016 In IDLE, edges SHALL be ignored and the bit counter SHALL be held at 0.
REQ-017 In SHIFT, on each detected edge miso SHALL be shifted into the shift register (direction per MSB_FIRST) and the bit counter incremented.
REQ-018 On the edge that brings the bit counter to DATA_W, the counter SHALL wrap to 0 and the word SHALL complete; rx_data/rx_valid SHALL update on the next clk_in rising edge (latency: 1 cycle after the final sampling edge).
REQ-019 A completion with rx_valid=0, or with rx_valid=1 and rx_ready=1 in the same cycle, SHALL load rx_data and set rx_valid=1.
REQ-020 A completion with rx_valid=1 and rx_ready=0 SHALL discard the new word, leave rx_data unchanged, and set overrun=1.
REQ-021 A handshake (rx_valid=1, rx_ready=1) without simultaneous completion SHALL clear rx_valid on the next cycle.
REQ-022 overrun_clr=1 SHALL clear overrun next cycle; if a new overrun occurs in the same cycle, overrun SHALL remain 1 (set wins).
REQ-023 en falling mid-word SHALL discard partial bits, reset the counter to 0 and return to IDLE; rx_data, rx_valid and overrun SHALL be unaffected.
REQ-024 An sclk edge in the same cycle en falls SHALL be ignored.
REQ-025 sclk held constant SHALL produce no edges; the block SHALL wait indefinitely without timeout.
REQ-026 The edge-detect history register SHALL keep tracking sclk in IDLE, so an sclk already high when en rises does not generate an edge.

Reset
REQ-027 While rst=1: state=IDLE, bit counter=0, shift register=0, sclk history=0, rx_data=0, rx_valid=0, overrun=0, busy=0.
REQ-028 Reset mid-word SHALL abandon the word with no completion after release.

Structure
REQ-029 A shared package spi_pkg SHALL hold the FSM state enumeration (IDLE, SHIFT) and the default DATA_W constant.
REQ-030 Edge detection SHALL be a sub-module sclk_edge_det (inputs clk_in, rst, sclk; output rise pulse).
REQ-031 Bit counter width SHALL be $clog2(DATA_W+1) bits; no other arithmetic is required.

Verification
REQ-032 en=1, sclk from divide-by-4 divider, miso sequence 1,0,1,0,0,1,0,1, MSB_FIRST=1, rx_ready=1 -> rx_data=8'hA5, rx_valid high one cycle after 8th edge.
REQ-033 Same stimulus, MSB_FIRST=0 -> rx_data=8'hA5 bit-reversed = 8'hA5 reversed (8'hA5 -> 8'hA5 is palindromic, so use 8'h01 pattern: miso 1,0,0,0,0,0,0,0 -> rx_data=8'h01).
REQ-034 Two words 8'h3C then 8'hC3 with rx_ready=0 -> rx_data stays 8'h3C, overrun=1; pulse overrun_clr -> overrun=0.
REQ-035 en dropped after 5 edges, then full word 8'h96 -> rx_data=8'h96, no partial-data contamination, rx_valid set once.
REQ-036 rst asserted after 3 edges, released, sclk continues with en=1 -> all outputs 0 during reset; first completion only after 8 fresh edges.
REQ-037 rx_ready=1 exactly in the completion cycle of word 8'h5A while 8'h11 pending -> rx_data=8'h5A, rx_valid stays 1, overrun=0.
